// File: rtl/data_ram_arb_pkg.sv
// data_ram_arb_pkg: shared types and default sizes for the DataRAM arbiter.
package data_ram_arb_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  typedef logic port_id_t;
endpackage

// File: rtl/data_ram_arbiter_arb_rr2.sv
// arb_rr2: two-way picker; on a tie force_switch hands off from last_gnt,
// otherwise the last winner keeps the grant.
module arb_rr2
  import data_ram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_gnt,
  input  logic     force_switch,
  output logic     gnt0,
  output logic     gnt1
);
  always_comb begin
    gnt0 = req0 & (~req1 | (force_switch ? last_gnt : ~last_gnt));
    gnt1 = req1 & ~gnt0;
  end
endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: round-robin sharing of one DataRAM between the core (port 0)
// and the loader (port 1), with bounded burst lock and 1-cycle read return.
module data_ram_arbiter
  import data_ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] DataSrc,
  input  logic [DW-1:0] DataMemOut
);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t state_q, state_d, own_g;
  logic [CW-1:0] cnt_q, cnt_d;
  port_id_t last_q, last_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic keep, any_g, lock_g;
  // Owner keeps a tie only while it still locks and has burst budget left.
  always_comb keep = ((state_q == OWN0 & lock0) | (state_q == OWN1 & lock1)) & (cnt_q < CW'(MAX_BURST));
  arb_rr2 u_arb (
    .req0        (req0 & Reset_n),
    .req1        (req1 & Reset_n),
    .last_gnt    (last_q),
    .force_switch(~keep),
    .gnt0        (gnt0),
    .gnt1        (gnt1)
  );
  always_comb begin
    Address   = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    DataSrc   = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    MemWrite  = (gnt0 & we0) | (gnt1 & we1);
    MemRead   = (gnt0 & ~we0) | (gnt1 & ~we1);
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? DataMemOut : rdata0_q;
    rdata1_d  = rvalid1_d ? DataMemOut : rdata1_q;
    any_g     = gnt0 | gnt1;
    lock_g    = any_g & (gnt0 ? lock0 : lock1);
    own_g     = gnt1 ? OWN1 : OWN0;
    last_d    = any_g ? gnt1 : last_q;
    state_d   = lock_g ? own_g : IDLE;
    cnt_d     = ~lock_g ? '0 : state_q != own_g ? CW'(1) : cnt_q == CW'(MAX_BURST) ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed vectors against a behavioural 256x8 RAM.
module tb_data_ram_arbiter;
  import data_ram_arb_pkg::*;
  logic CLK = 1'b0, Reset_n = 1'b0, ld = 1'b1;
  logic req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, MemRead, MemWrite;
  logic [7:0] rdata0, rdata1, Address, DataSrc, DataMemOut;
  logic [7:0] ram [256];
  logic [5:0] pat;
  int n_chk = 0, n_err = 0;

  data_ram_arbiter dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .DataSrc(DataSrc),
    .DataMemOut(DataMemOut)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[8'h05] <= 8'hA7;
      ram[8'h40] <= 8'h4A;
      ram[8'h41] <= 8'h4B;
    end else if (MemWrite) ram[Address] <= DataSrc;
  end
  assign DataMemOut = ram[Address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, l0, input logic [7:0] a0, d0,
                       input logic r1, w1, l1, input logic [7:0] a1, d1);
    @(negedge CLK);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    Reset_n = 1'b0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  initial begin
    req0 = 1; we0 = 1;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_memwrite", MemWrite, 0);
    repeat (2) @(negedge CLK);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    req0 = 0; we0 = 0; ld = 0; Reset_n = 1;

    drive(1, 0, 0, 8'h05, 0, 0, 0, 0, 0, 0);
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_memread", MemRead, 1);
    check("rd_memwrite", MemWrite, 0);
    check("rd_addr", Address, 8'h05);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rdata0", rdata0, 8'hA7);
    check("rd_rvalid1", rvalid1, 0);
    check("idle_memread", MemRead, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_strobe_end", rvalid0, 0);
    check("rd_hold", rdata0, 8'hA7);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8'h40, 0, 1, 0, 0, 8'h41, 0);
      check($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2) == 0);
      check($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2) == 1);
      check($sformatf("rr_rv0_%0d", i), rvalid0, (i > 0) && ((i - 1) % 2 == 0));
      check($sformatf("rr_rv1_%0d", i), rvalid1, (i > 0) && ((i - 1) % 2 == 1));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rr_last_rv1", rvalid1, 1);
    check("rr_rdata0", rdata0, 8'h4A);
    check("rr_rdata1", rdata1, 8'h4B);

    do_reset();
    pat = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 8'h40, 0, 1, 0, 0, 8'h41, 0);
      check($sformatf("burst_gnt0_%0d", i), gnt0, pat[i]);
      check($sformatf("burst_gnt1_%0d", i), gnt1, !pat[i]);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 8'h10, 8'h3C);
    check("wr_gnt1", gnt1, 1);
    check("wr_memwrite", MemWrite, 1);
    check("wr_memread", MemRead, 0);
    check("wr_addr", Address, 8'h10);
    check("wr_data", DataSrc, 8'h3C);
    drive(1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    check("raw_gnt0", gnt0, 1);
    check("wr_no_rvalid1", rvalid1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("raw_rvalid0", rvalid0, 1);
    check("raw_rdata0", rdata0, 8'h3C);

    do_reset();
    drive(1, 1, 0, 8'h20, 8'h11, 1, 1, 0, 8'h20, 8'h22);
    check("ww_gnt0", gnt0, 1);
    check("ww_gnt1", gnt1, 0);
    check("ww_data", DataSrc, 8'h11);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 8'h20, 8'h22);
    check("ww_ram_first", ram[8'h20], 8'h11);
    check("ww_retry_gnt1", gnt1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ww_ram_second", ram[8'h20], 8'h22);

    drive(1, 0, 1, 8'h05, 0, 0, 0, 0, 0, 0);
    check("mb_gnt0", gnt0, 1);
    drive(1, 1, 1, 8'h30, 8'h55, 0, 0, 0, 0, 0);
    check("mb_owner", dut.state_q, OWN0);
    check("mb_rvalid0_pre", rvalid0, 1);
    check("mb_memwrite_pre", MemWrite, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("mb_memwrite_rst", MemWrite, 0);
    check("mb_gnt0_rst", gnt0, 0);
    check("mb_rvalid0_rst", rvalid0, 0);
    @(negedge CLK);
    req0 = 0; we0 = 0; lock0 = 0;
    Reset_n = 1'b1;
    #1;
    check("mb_ram30", ram[8'h30], 8'h00);
    check("mb_rvalid0", rvalid0, 0);
    check("mb_rvalid1", rvalid1, 0);
    check("mb_state", dut.state_q, IDLE);
    check("mb_cnt", dut.cnt_q, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single 256x8 DataRAM between two requesters: port 0 is the core load/store stage, port 1 is the init/DMA loader.
- Grants at most one access per cycle. Arbitration is round-robin, with an optional bounded burst lock.
- Drives the RAM's MemRead/MemWrite/Address/DataSrc controls directly.
- Returns read data to the winning requester one cycle later with a valid strobe.

Parameters:
- AW, 8, address width (RAM depth 2**AW).
- DW, 8, data width.
- MAX_BURST, 4, maximum consecutive locked grants to one requester while the other waits (>=1).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 access request; held with fields stable until gnt0.
- we0  input  1  port 0 write enable (1=write, 0=read).
- lock0  input  1  port 0 requests to keep the grant on following cycles.
- addr0  input  AW  port 0 address.
- wdata0  input  DW  port 0 write data.
- gnt0  output  1  port 0 accepted this cycle (combinational).
- rdata0  output  DW  port 0 registered read data.
- rvalid0  output  1  one-cycle strobe: rdata0 valid.
- req1, we1, lock1, addr1, wdata1, gnt1, rdata1, rvalid1: port 1 equivalents, same widths.
- MemRead  output  1  RAM read enable.
- MemWrite  output  1  RAM write enable; RAM writes on CLK rising edge.
- Address  output  AW  RAM address.
- DataSrc  output  DW  RAM write data.
- DataMemOut  input  DW  RAM read data; asynchronous, valid in the same cycle as Address.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State=IDLE, last_gnt=1 (port 0 wins the first tie), burst_cnt=0.
  - rdata0/1=0, rvalid0/1=0.
  - gnt0/1, MemRead and MemWrite are forced 0 combinationally while Reset_n=0, so no RAM write occurs during a reset cycle.
- Grant decision (combinational, per cycle):
  - Neither req: no gnt. MemRead=MemWrite=0, Address=0, DataSrc=0.
  - One req: that port is granted.
  - Both req, state IDLE: grant the port != last_gnt.
  - Both req, state OWNn with burst_cnt<MAX_BURST and reqn&lockn: grant n.
  - Both req, state OWNn with burst_cnt==MAX_BURST: grant the other port.
- Granted port k drives the RAM:
  - Address=addrk.
  - MemWrite=wek, DataSrc=wdatak.
  - MemRead=~wek.
- Read return:
  - On a granted read, DataMemOut is captured into rdatak at the rising edge.
  - rvalidk=1 in the following cycle only.
  - Read latency is 1 cycle from gnt to rvalid.
  - rdatak holds its value until the next read by port k.
  - Writes never assert rvalid.
- FSM states IDLE, OWN0, OWN1, updated on the edge after a grant to port k:
  - lockk=1: go to OWNk. burst_cnt = (prev state OWNk) ? burst_cnt+1 : 1, saturating at MAX_BURST.
  - lockk=0: go to IDLE, burst_cnt=0.
  - last_gnt=k in both cases.
  - No grant this cycle: go to IDLE, burst_cnt=0.
- Lock rules:
  - Lock is advisory only; it never blocks a port when the other port is idle.
  - A locked port that drops req releases ownership.
- Boundary conditions:
  - Back-to-back write then read to the same address, either port: the read returns the new data (RAM write at edge N, read in cycle N+1).
  - Both ports write the same address in the same cycle: only the winner writes; the loser retries next cycle.
  - Reset asserted mid-burst: ownership and the counter clear immediately; a pending rvalid is dropped.

Decomposition:
- Package data_ram_arb_pkg:
  - AW/DW default localparams.
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t.
  - typedef logic port_id_t.
- Sub-module arb_rr2: combinational 2-way picker.
  - Inputs: req0, req1, last_gnt, force_switch.
  - Outputs: gnt0, gnt1.
- The FSM, burst counter, RAM mux and read-return registers stay in the top module.

Test Plan:
- Reset, then req0 only: read addr 0x05 (RAM 0x05=0xA7) -> gnt0 same cycle, MemRead=1, Address=0x05; next cycle rvalid0=1, rdata0=0xA7, rvalid1=0.
- req0 and req1 held continuously, lock=0, reads -> grants alternate 0,1,0,1 starting with port 0; each rvalid appears one cycle after its grant.
- lock0=1 with req0 and req1 held, MAX_BURST=4 -> gnt0 on 4 consecutive cycles, then gnt1 for 1 cycle, then gnt0 resumes.
- Port 1 writes 0x3C to 0x10, then port 0 reads 0x10 the next cycle -> rdata0=0x3C.
- Both ports write 0x20 (port 0: 0x11, port 1: 0x22), last_gnt=1 -> port 0 wins; RAM[0x20]=0x11; port 1 granted next cycle, leaving RAM[0x20]=0x22.
- Reset_n pulsed low during a granted write to 0x30 (old 0x00) with lock0 -> MemWrite=0 during reset, RAM[0x30] stays 0x00; rvalid0/1=0 and state=IDLE after release.
